// File: rtl/esteira_pkg.sv
// esteira_pkg: shared types and constants for the conveyor batch sequencer.
//   state_t : FSM state, 3-bit encoding shown on the STATE output/LEDs.
//   TGT_W   : width of the product target and the good-product counter.
package esteira_pkg;

    localparam int TGT_W = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        RUN   = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/esteira_if.sv
// esteira_if: operator-input and belt-datapath signals of the batch sequencer.
//   Operator side : TARGET, LOAD, START, STOP, MODE, KEY_P, PROD.
//   Datapath side : SHIFT_EN, SHIFT_BIT, CLR, COUNT, TGT, FIM, BUSY, STATE, BATCH.
//   master modport drives the operator side; slave modport is the sequencer.
interface esteira_if
    import esteira_pkg::*;
#(
    parameter int BATCH_W = 8
);

    logic [TGT_W-1:0]   TARGET;
    logic               LOAD;
    logic               START;
    logic               STOP;
    logic               MODE;
    logic               KEY_P;
    logic               PROD;

    logic               SHIFT_EN;
    logic               SHIFT_BIT;
    logic               CLR;
    logic [TGT_W-1:0]   COUNT;
    logic [TGT_W-1:0]   TGT;
    logic               FIM;
    logic               BUSY;
    logic [2:0]         STATE;
    logic [BATCH_W-1:0] BATCH;

    modport master (
        output TARGET, LOAD, START, STOP, MODE, KEY_P, PROD,
        input  SHIFT_EN, SHIFT_BIT, CLR, COUNT, TGT, FIM, BUSY, STATE, BATCH
    );

    modport slave (
        input  TARGET, LOAD, START, STOP, MODE, KEY_P, PROD,
        output SHIFT_EN, SHIFT_BIT, CLR, COUNT, TGT, FIM, BUSY, STATE, BATCH
    );

endinterface

// File: rtl/esteira_tick.sv
// esteira_tick: automatic belt-step divider.
//   CLK, RESET : clock, synchronous active-high reset.
//   EN         : count enable (high only while the batch is running).
//   CLR_CNT    : restart the count from 0 (new batch).
//   TICK       : high during the enabled cycle in which the count is at TICK_DIV-1.
module esteira_tick #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic CLK,
    input  logic RESET,
    input  logic EN,
    input  logic CLR_CNT,
    output logic TICK
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge CLK) begin
        if (RESET || CLR_CNT) begin
            cnt <= '0;
        end else if (EN) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign TICK = EN && (cnt == LAST);

endmodule

// File: rtl/esteira_ctrl.sv
// esteira_ctrl: conveyor batch sequencer.
//   CLK, RESET : clock, synchronous active-high reset.
//   bus        : esteira_if.slave; operator inputs in, belt/counter/status out.
// Captures a target, paces belt shifts from the internal tick (MODE=0) or
// KEY_P (MODE=1), counts good products, raises FIM on completion and counts
// completed batches. All outputs are registered.
module esteira_ctrl
    import esteira_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int BATCH_W  = 8
) (
    input logic     CLK,
    input logic     RESET,
    esteira_if.slave bus
);

    state_t             state;
    logic [TGT_W-1:0]   tgt;
    logic [TGT_W-1:0]   count;
    logic [BATCH_W-1:0] batch;
    logic               shift_en;
    logic               shift_bit;
    logic               clr;
    logic               fim;
    logic               busy;

    logic               tick;
    logic               step;
    logic               load_ok;
    logic               start_new;
    logic [TGT_W-1:0]   count_inc;

    // A fresh batch (from ARMED or DONE) restarts the divider; a resume from
    // PAUSE keeps the partial count.
    assign start_new = bus.START && (state == ARMED || state == DONE);
    assign step      = bus.MODE ? bus.KEY_P : tick;
    assign load_ok   = bus.LOAD && (bus.TARGET != '0);
    assign count_inc = count + 1'b1;

    esteira_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .CLK     (CLK),
        .RESET   (RESET),
        .EN      (state == RUN),
        .CLR_CNT (start_new),
        .TICK    (tick)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            tgt       <= '0;
            count     <= '0;
            batch     <= '0;
            shift_en  <= 1'b0;
            shift_bit <= 1'b0;
            clr       <= 1'b0;
            fim       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            shift_en  <= 1'b0;
            shift_bit <= 1'b0;
            clr       <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_ok) begin
                        tgt   <= bus.TARGET;
                        state <= ARMED;
                    end
                end
                ARMED: begin
                    if (bus.START) begin
                        clr   <= 1'b1;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else if (load_ok) begin
                        tgt <= bus.TARGET;
                    end
                end
                RUN: begin
                    // STOP outranks a coincident step; START and LOAD do nothing here.
                    if (bus.STOP) begin
                        busy  <= 1'b0;
                        state <= PAUSE;
                    end else if (step) begin
                        shift_en  <= 1'b1;
                        shift_bit <= bus.PROD;
                        if (bus.PROD) begin
                            count <= count_inc;
                            if (count_inc == tgt) begin
                                fim   <= 1'b1;
                                busy  <= 1'b0;
                                batch <= batch + 1'b1;
                                state <= DONE;
                            end
                        end
                    end
                end
                PAUSE: begin
                    if (bus.START) begin
                        busy  <= 1'b1;
                        state <= RUN;
                    end else if (load_ok) begin
                        tgt   <= bus.TARGET;
                        count <= '0;
                        clr   <= 1'b1;
                        state <= ARMED;
                    end
                end
                DONE: begin
                    if (bus.START) begin
                        clr   <= 1'b1;
                        count <= '0;
                        fim   <= 1'b0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else if (load_ok) begin
                        tgt   <= bus.TARGET;
                        fim   <= 1'b0;
                        state <= ARMED;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.SHIFT_EN  = shift_en;
    assign bus.SHIFT_BIT = shift_bit;
    assign bus.CLR       = clr;
    assign bus.COUNT     = count;
    assign bus.TGT       = tgt;
    assign bus.FIM       = fim;
    assign bus.BUSY      = busy;
    assign bus.STATE     = state;
    assign bus.BATCH     = batch;

endmodule
